// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin hold arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        GRANT = 2'b10
    } arb_state_e;

    // Index width for a requester vector; never below one bit.
    function automatic int calc_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating find-first: scans req from start_i with wrap, skipping bits cleared in mask_i.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ-1:0]              mask_i,
    input  logic [calc_id_w(NUM_REQ)-1:0]   start_i,
    output logic                            found_o,
    output logic [calc_id_w(NUM_REQ)-1:0]   idx_o
);

    localparam int ID_W = calc_id_w(NUM_REQ);

    logic [NUM_REQ-1:0] cand;
    logic               hit;
    logic [ID_W-1:0]    idx;
    int                 j;

    always_comb begin
        cand = req_i & mask_i;
        hit  = 1'b0;
        idx  = '0;
        j    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(start_i) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!hit && cand[j]) begin
                hit = 1'b1;
                idx = ID_W'(j);
            end
        end
    end

    assign found_o = hit;
    assign idx_o   = idx;

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold: the holder keeps the resource while it
// requests, bounded to MAX_HOLD cycles whenever someone else is waiting.
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            gnt_valid,
    output logic [calc_id_w(NUM_REQ)-1:0]   gnt_id,
    output logic                            preempt
);

    localparam int ID_W  = calc_id_w(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(NUM_REQ - 1);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]    hold_q, hold_d;
    logic                pre_q, pre_d;

    logic [ID_W-1:0]     start;
    logic [NUM_REQ-1:0]  mask;
    logic                found;
    logic [ID_W-1:0]     win;
    logic                holder_req;
    logic                others;

    assign start      = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;
    // Exclude the current holder so a handoff always goes to someone else.
    assign mask       = (state_q == GRANT) ? ~gnt_q : '1;
    assign holder_req = |(req & gnt_q);
    assign others     = |(req & ~gnt_q);

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i   (req),
        .mask_i  (mask),
        .start_i (start),
        .found_o (found),
        .idx_o   (win)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        last_d  = last_q;
        hold_d  = hold_q;
        pre_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = GRANT;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    id_d       = win;
                    last_d     = win;
                    hold_d     = CNT_W'(1);
                end
            end
            GRANT: begin
                if (holder_req && (!others || hold_q < HOLD_MAX)) begin
                    if (hold_q < HOLD_MAX) hold_d = hold_q + 1'b1;
                end else if (found) begin
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    id_d       = win;
                    last_d     = win;
                    hold_d     = CNT_W'(1);
                    pre_d      = holder_req;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            last_q  <= LAST_IDX;
            hold_q  <= '0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            pre_q   <= pre_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = id_q;
    assign preempt   = pre_q;

    a_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(gnt_q));
    a_valid:  assert property (@(posedge clock) disable iff (reset) gnt_valid == (|gnt));
    a_rise:   assert property (@(posedge clock) disable iff (reset)
                  (gnt_q & ~$past(gnt_q) & ~$past(req)) == '0);
    a_hold:   assert property (@(posedge clock) disable iff (reset)
                  (state_q == GRANT && holder_req && others && hold_q == HOLD_MAX)
                  |=> gnt_q != $past(gnt_q));

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Randomised and directed checks of two arbiter instances (MAX_HOLD 8 and 1)
// against a cycle-level reference model built on owner/run-length bookkeeping.
module tb_rr_hold_arbiter;

    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req   = '0;

    logic [N-1:0]   gnt_a, gnt_b;
    logic           val_a, val_b;
    logic [1:0]     id_a, id_b;
    logic           pre_a, pre_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    rr_hold_arbiter #(.NUM_REQ(N), .MAX_HOLD(8)) u_dut8 (
        .clock(clock), .reset(reset), .req(req),
        .gnt(gnt_a), .gnt_valid(val_a), .gnt_id(id_a), .preempt(pre_a)
    );

    rr_hold_arbiter #(.NUM_REQ(N), .MAX_HOLD(1)) u_dut1 (
        .clock(clock), .reset(reset), .req(req),
        .gnt(gnt_b), .gnt_valid(val_b), .gnt_id(id_b), .preempt(pre_b)
    );

    // Reference model: owner index (-1 = none), consecutive cycles owned,
    // pointer of the most recent winner, reported id, preempt pulse.
    int         m_own  [2];
    int         m_run  [2];
    int         m_last [2];
    int         m_id   [2];
    logic       m_pre  [2];
    int         m_max  [2] = '{8, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input logic [N-1:0] r, input logic rst);
        bit others;
        bit found;
        int nxt;
        if (rst) begin
            m_own[k] = -1; m_run[k] = 0; m_last[k] = N - 1; m_id[k] = 0; m_pre[k] = 0;
            return;
        end
        m_pre[k] = 0;
        others = 0;
        for (int j = 0; j < N; j++) if (r[j] && j != m_own[k]) others = 1;
        found = 0;
        nxt = 0;
        for (int s = 1; s <= N; s++) begin
            int j = (m_last[k] + s) % N;
            if (!found && r[j] && j != m_own[k]) begin
                found = 1;
                nxt = j;
            end
        end
        if (m_own[k] < 0) begin
            if (found) begin
                m_own[k] = nxt; m_run[k] = 1; m_last[k] = nxt; m_id[k] = nxt;
            end
        end else if (r[m_own[k]] && (!others || m_run[k] < m_max[k])) begin
            m_run[k]++;
        end else if (others) begin
            m_pre[k] = r[m_own[k]];
            m_own[k] = nxt; m_run[k] = 1; m_last[k] = nxt; m_id[k] = nxt;
        end else begin
            m_own[k] = -1; m_run[k] = 0;
        end
    endtask

    function automatic logic [N-1:0] exp_gnt(input int k);
        logic [N-1:0] g;
        g = '0;
        if (m_own[k] >= 0) g[m_own[k]] = 1'b1;
        return g;
    endfunction

    task automatic cyc(input logic [N-1:0] r, input logic rst);
        @(negedge clock);
        req   = r;
        reset = rst;
        @(posedge clock);
        model_step(0, r, rst);
        model_step(1, r, rst);
        #1;
        chk("gnt8",   32'(gnt_a), 32'(exp_gnt(0)));
        chk("val8",   32'(val_a), 32'(exp_gnt(0) != '0));
        chk("id8",    32'(id_a),  32'(m_id[0]));
        chk("pre8",   32'(pre_a), 32'(m_pre[0]));
        chk("gnt1",   32'(gnt_b), 32'(exp_gnt(1)));
        chk("val1",   32'(val_b), 32'(exp_gnt(1) != '0));
        chk("id1",    32'(id_b),  32'(m_id[1]));
        chk("pre1",   32'(pre_b), 32'(m_pre[1]));
    endtask

    initial begin
        logic [N-1:0] rem;
        logic [N-1:0] r;
        logic         rs;

        cyc('0, 1'b1);
        cyc('0, 1'b1);
        chk("rst_gnt", 32'(gnt_a), 32'h0);

        // Grant then handoff without bubble.
        cyc(4'b0101, 1'b0);
        chk("first_gnt", 32'(gnt_a), 32'h1);
        cyc(4'b0100, 1'b0);
        chk("handoff", 32'(gnt_a), 32'h4);
        cyc('0, 1'b0);
        cyc('0, 1'b0);

        // Two continuous requesters: periodic preemption.
        repeat (20) cyc(4'b0011, 1'b0);
        cyc('0, 1'b0);
        cyc('0, 1'b0);

        // Sole holder saturates, newcomer preempts immediately.
        repeat (20) cyc(4'b0100, 1'b0);
        cyc(4'b1100, 1'b0);
        chk("late_pre", 32'(pre_a), 32'h1);
        cyc(4'b1100, 1'b0);
        cyc('0, 1'b0);
        cyc('0, 1'b0);

        // Everyone requests, each drops on its first grant cycle.
        rem = 4'b1111;
        repeat (7) begin
            rem = rem & ~exp_gnt(0);
            cyc(rem, 1'b0);
        end
        chk("drain", 32'(val_a), 32'h0);

        // Reset mid-grant, then search restarts from requester 0.
        cyc(4'b0100, 1'b0);
        cyc(4'b0100, 1'b0);
        cyc(4'b0100, 1'b1);
        cyc(4'b1100, 1'b0);
        chk("post_rst", 32'(gnt_a), 32'h4);

        // Strict rotation on the MAX_HOLD=1 instance.
        cyc('0, 1'b1);
        repeat (12) cyc(4'b1011, 1'b0);
        cyc('0, 1'b0);

        // Random phase with sticky request patterns and rare resets.
        r = '0;
        repeat (1500) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom);
            rs = ($urandom_range(0, 199) == 0);
            cyc(r, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
